led_frame_scheduler: RTL and testbench

Owns the single WS2812 GRB LED chain and shares it between two frame sources: the game engine's live frame and the win/attract animation generator. It arbitrates their refresh requests round-robin and latches the granted frame. It then serialises the frame MSB-first with WS2812 bit timing and enforces the latch/reset low period before the next frame. It sits between the game/animation logic and the physical data pin.

---
 rtl/led_pkg.sv | 39 +++
 rtl/ws2812_bit_encoder.sv | 39 +++
 rtl/led_frame_scheduler.sv | 170 +++++++++++++++++
 tb/tb_led_frame_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Package     : led_pkg
// Description : Shared definitions for the WS2812 LED chain. Used by the frame
//               scheduler, the game engine and the animation generator. Holds
//               the GRB pixel width, default chain length and timing, the
//               scheduler state type, the requester id type and a helper that
//               derives the frame width from the LED count.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int GRB_W        = 24;
    localparam int NUM_LEDS_DEF = 5;

    // Default WS2812 timing in clk cycles
    localparam int T_BIT_DEF    = 125;
    localparam int T0H_DEF      = 40;
    localparam int T1H_DEF      = 80;
    localparam int T_RST_DEF    = 6000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } led_state_t;

    typedef enum logic {
        GAME = 1'b0,
        ANIM = 1'b1
    } req_id_t;

    // Width of a packed GRB frame for a chain of num_leds LEDs
    function automatic int frame_w(input int num_leds);
        return GRB_W * num_leds;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_bit_encoder.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_bit_encoder
// Description : WS2812 bit-slot waveform decode. Given the bit being sent and
//               the position inside its slot, gives the line level and flags
//               the last cycle of the slot. The scheduler drives it with its
//               next-state values so both results can be registered and line
//               up with the counter in the following cycle.
// Ports       : i_start    - a bit slot is active (scheduler is sending)
//               i_tx_bit   - value of the bit in the slot
//               i_tcnt     - cycle position inside the slot
//               o_dout_bit - line level for this position
//               o_bit_last - position is the final cycle of the slot
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812_bit_encoder
    import led_pkg::*;
#(
    parameter int T_BIT = T_BIT_DEF,
    parameter int T0H   = T0H_DEF,
    parameter int T1H   = T1H_DEF,
    parameter int CNT_W = 13
) (
    input  logic             i_start,
    input  logic             i_tx_bit,
    input  logic [CNT_W-1:0] i_tcnt,
    output logic             o_dout_bit,
    output logic             o_bit_last
);

    localparam logic [CNT_W-1:0] c_t0h      = CNT_W'(T0H);
    localparam logic [CNT_W-1:0] c_t1h      = CNT_W'(T1H);
    localparam logic [CNT_W-1:0] c_bit_last = CNT_W'(T_BIT - 1);

    assign o_dout_bit = i_start && (i_tcnt < (i_tx_bit ? c_t1h : c_t0h));
    assign o_bit_last = i_start && (i_tcnt == c_bit_last);

endmodule
`default_nettype wire

// File: rtl/led_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : led_frame_scheduler
// Description : Shares one WS2812 GRB chain between the game frame and the
//               animation frame. Round-robin arbitration of refresh requests
//               in IDLE, latches the granted frame, shifts it out MSB-first
//               with WS2812 bit timing, then holds the line low for the chain
//               latch period before returning to IDLE.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               game_req/game_frame - game refresh request and frame
//               anim_req/anim_frame - animation refresh request and frame
//               game_grant          - pulse: game frame latched
//               anim_grant          - pulse: animation frame latched
//               busy                - not in IDLE
//               dout                - serial data to the LED chain
//               frame_done          - pulse in the first IDLE cycle after latch
// Revision    : 1.0 - initial release
// ============================================================================
module led_frame_scheduler
    import led_pkg::*;
#(
    parameter int  NUM_LEDS = NUM_LEDS_DEF,
    parameter int  T_BIT    = T_BIT_DEF,
    parameter int  T0H      = T0H_DEF,
    parameter int  T1H      = T1H_DEF,
    parameter int  T_RST    = T_RST_DEF,
    localparam int FRAME_W  = frame_w(NUM_LEDS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               game_req,
    input  logic [FRAME_W-1:0] game_frame,
    input  logic               anim_req,
    input  logic [FRAME_W-1:0] anim_frame,
    output logic               game_grant,
    output logic               anim_grant,
    output logic               busy,
    output logic               dout,
    output logic               frame_done
);

    localparam int c_tcnt_w = $clog2((T_BIT > T_RST) ? T_BIT : T_RST);
    localparam int c_idx_w  = $clog2(FRAME_W);

    localparam logic [c_idx_w-1:0]  c_idx_last = c_idx_w'(FRAME_W - 1);
    localparam logic [c_tcnt_w-1:0] c_rst_last = c_tcnt_w'(T_RST - 1);

    if (!((T0H > 0) && (T0H < T1H) && (T1H < T_BIT) && (T_RST > 0))) begin : g_param_check
        $error("led_frame_scheduler: illegal timing, need 0 < T0H < T1H < T_BIT and T_RST > 0");
    end

    led_state_t            r_state, w_state_nxt;
    req_id_t               r_last, w_last_nxt;
    logic [c_tcnt_w-1:0]   r_tcnt, w_tcnt_nxt;
    logic [c_idx_w-1:0]    r_bit_idx, w_bit_idx_nxt;
    logic [FRAME_W-1:0]    r_shift, w_shift_nxt;
    logic                  w_game_grant_nxt, w_anim_grant_nxt, w_frame_done_nxt;
    logic                  r_game_grant, r_anim_grant, r_frame_done;
    logic                  r_dout, r_busy, r_bit_last;
    logic                  w_dout_bit, w_bit_last, w_send_nxt;

    always_comb begin
        w_state_nxt      = r_state;
        w_last_nxt       = r_last;
        w_tcnt_nxt       = r_tcnt;
        w_bit_idx_nxt    = r_bit_idx;
        w_shift_nxt      = r_shift;
        w_game_grant_nxt = 1'b0;
        w_anim_grant_nxt = 1'b0;
        w_frame_done_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                // Game wins when alone or when the previous grant went to anim
                if (game_req && (!anim_req || (r_last == ANIM))) begin
                    w_state_nxt      = SEND;
                    w_shift_nxt      = game_frame;
                    w_game_grant_nxt = 1'b1;
                    w_last_nxt       = GAME;
                    w_tcnt_nxt       = '0;
                    w_bit_idx_nxt    = c_idx_last;
                end else if (anim_req) begin
                    w_state_nxt      = SEND;
                    w_shift_nxt      = anim_frame;
                    w_anim_grant_nxt = 1'b1;
                    w_last_nxt       = ANIM;
                    w_tcnt_nxt       = '0;
                    w_bit_idx_nxt    = c_idx_last;
                end
            end
            SEND: begin
                if (r_bit_last) begin
                    w_tcnt_nxt = '0;
                    if (r_bit_idx != '0) begin
                        w_shift_nxt   = r_shift << 1;
                        w_bit_idx_nxt = r_bit_idx - 1'b1;
                    end else begin
                        w_state_nxt = LATCH;
                    end
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end
            LATCH: begin
                if (r_tcnt == c_rst_last) begin
                    w_state_nxt      = IDLE;
                    w_tcnt_nxt       = '0;
                    w_frame_done_nxt = 1'b1;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_send_nxt = (w_state_nxt == SEND);

    // Fed with next-state values so dout and the end-of-slot flag are
    // registered alongside the counter they describe.
    ws2812_bit_encoder #(
        .T_BIT (T_BIT),
        .T0H   (T0H),
        .T1H   (T1H),
        .CNT_W (c_tcnt_w)
    ) u_bit_encoder (
        .i_start    (w_send_nxt),
        .i_tx_bit   (w_shift_nxt[FRAME_W-1]),
        .i_tcnt     (w_tcnt_nxt),
        .o_dout_bit (w_dout_bit),
        .o_bit_last (w_bit_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last       <= ANIM;
            r_tcnt       <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_game_grant <= 1'b0;
            r_anim_grant <= 1'b0;
            r_frame_done <= 1'b0;
            r_dout       <= 1'b0;
            r_busy       <= 1'b0;
            r_bit_last   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last       <= w_last_nxt;
            r_tcnt       <= w_tcnt_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_game_grant <= w_game_grant_nxt;
            r_anim_grant <= w_anim_grant_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_dout       <= w_dout_bit;
            r_busy       <= (w_state_nxt != IDLE);
            r_bit_last   <= w_bit_last;
        end
    end

    assign game_grant = r_game_grant;
    assign anim_grant = r_anim_grant;
    assign busy       = r_busy;
    assign dout       = r_dout;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_led_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_frame_scheduler
// Description : Self-checking bench. Three schedulers run side by side: two
//               with default timing (single-source / resets, and round-robin
//               ties) and one with short override timing. A frame-level
//               model predicts every output each cycle; directed checks pin
//               waveform run lengths and grant spacing with literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_frame_scheduler;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // unit 0 and 1: default parameters, unit 2: override parameters
    logic         rst0, greq0, areq0, gg0, ag0, busy0, dout0, fd0;
    logic [119:0] gf0, af0;
    logic         rst1, greq1, areq1, gg1, ag1, busy1, dout1, fd1;
    logic [119:0] gf1, af1;
    logic         rst2, greq2, areq2, gg2, ag2, busy2, dout2, fd2;
    logic [23:0]  gf2, af2;
    bit           done0, done1, done2;

    led_frame_scheduler u_dut0 (
        .clk(clk), .reset(rst0), .game_req(greq0), .game_frame(gf0),
        .anim_req(areq0), .anim_frame(af0), .game_grant(gg0), .anim_grant(ag0),
        .busy(busy0), .dout(dout0), .frame_done(fd0)
    );

    led_frame_scheduler u_dut1 (
        .clk(clk), .reset(rst1), .game_req(greq1), .game_frame(gf1),
        .anim_req(areq1), .anim_frame(af1), .game_grant(gg1), .anim_grant(ag1),
        .busy(busy1), .dout(dout1), .frame_done(fd1)
    );

    led_frame_scheduler #(
        .NUM_LEDS(1), .T_BIT(10), .T0H(3), .T1H(7), .T_RST(20)
    ) u_dut2 (
        .clk(clk), .reset(rst2), .game_req(greq2), .game_frame(gf2),
        .anim_req(areq2), .anim_frame(af2), .game_grant(gg2), .anim_grant(ag2),
        .busy(busy2), .dout(dout2), .frame_done(fd2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // ---------------- frame-level model ----------------
    int           m_fw[3] = '{120, 120, 24};
    int           m_tb[3] = '{125, 125, 10};
    int           m_t0[3] = '{40, 40, 3};
    int           m_t1[3] = '{80, 80, 7};
    int           m_tr[3] = '{6000, 6000, 20};
    bit           m_act[3];
    int           m_k[3];
    logic [119:0] m_frame[3];
    bit           m_last_anim[3];
    bit           e_gg[3], e_ag[3], e_fd[3];

    // One clock edge: m_k is the cycle offset from the grant cycle
    task automatic model_step(input int u, input logic rst, input logic gr, input logic ar,
                              input logic [119:0] gf, input logic [119:0] af);
        e_gg[u] = 1'b0;
        e_ag[u] = 1'b0;
        e_fd[u] = 1'b0;
        if (rst) begin
            m_act[u]       = 1'b0;
            m_last_anim[u] = 1'b1;
        end else if (m_act[u]) begin
            m_k[u]++;
            if (m_k[u] == m_fw[u] * m_tb[u] + m_tr[u]) begin
                m_act[u] = 1'b0;
                e_fd[u]  = 1'b1;
            end
        end else if (gr && (!ar || m_last_anim[u])) begin
            m_act[u] = 1'b1; m_k[u] = 0; m_frame[u] = gf;
            e_gg[u] = 1'b1; m_last_anim[u] = 1'b0;
        end else if (ar) begin
            m_act[u] = 1'b1; m_k[u] = 0; m_frame[u] = af;
            e_ag[u] = 1'b1; m_last_anim[u] = 1'b1;
        end
    endtask

    function automatic logic [4:0] exp_vec(input int u);
        logic b;
        logic d;
        d = 1'b0;
        if (m_act[u] && (m_k[u] < m_fw[u] * m_tb[u])) begin
            b = m_frame[u][m_fw[u] - 1 - m_k[u] / m_tb[u]];
            d = ((m_k[u] % m_tb[u]) < (b ? m_t1[u] : m_t0[u]));
        end
        return {e_gg[u], e_ag[u], m_act[u], d, e_fd[u]};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            model_step(0, rst0, greq0, areq0, gf0, af0);
            model_step(1, rst1, greq1, areq1, gf1, af1);
            model_step(2, rst2, greq2, areq2, {96'd0, gf2}, {96'd0, af2});
        end
    end

    // Compare {game_grant, anim_grant, busy, dout, frame_done} every cycle
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("u0 outputs {gg,ag,busy,dout,fd}", {gg0, ag0, busy0, dout0, fd0}, exp_vec(0));
            check("u1 outputs {gg,ag,busy,dout,fd}", {gg1, ag1, busy1, dout1, fd1}, exp_vec(1));
            check("u2 outputs {gg,ag,busy,dout,fd}", {gg2, ag2, busy2, dout2, fd2}, exp_vec(2));
        end
    end

    // ---------------- unit 0: single source, ignored inputs, resets ----------------
    initial begin
        int  k, len, gcount;
        bit  cur;
        int  runs[$];
        rst0 = 1'b1; greq0 = 1'b0; areq0 = 1'b0;
        gf0  = {24'hFF0000, 96'd0}; af0 = '0;
        repeat (2) @(negedge clk);
        check("u0 reset outputs", {gg0, ag0, busy0, dout0, fd0}, 5'b0);
        rst0 = 1'b0; greq0 = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!gg0 && k < 5);
        check("u0 first grant latency", k, 1);
        check("u0 grant is game", {gg0, ag0}, 2'b10);
        check("u0 busy in grant cycle", busy0, 1'b1);
        cur = dout0; len = 1; k = 0;
        while (!fd0 && k < 21100) begin
            if (k == 3000) begin gf0 = '1; greq0 = 1'b0; end
            @(negedge clk); k++;
            if (fd0) runs.push_back(len);
            else if (dout0 == cur) len++;
            else begin runs.push_back(len); cur = dout0; len = 1; end
        end
        check("u0 grant-to-frame_done cycles", k, 21000);
        check("u0 dout run count", runs.size(), 240);
        if (runs.size() >= 240) begin
            check("u0 bit0 high", runs[0], 80);
            check("u0 bit0 low", runs[1], 45);
            check("u0 bit7 high", runs[14], 80);
            check("u0 bit7 low", runs[15], 45);
            check("u0 bit8 high", runs[16], 40);
            check("u0 bit8 low", runs[17], 85);
            check("u0 bit119 high", runs[238], 40);
            check("u0 last low incl latch", runs[239], 6085);
        end
        gcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (gg0 || ag0) gcount++;
        end
        check("u0 no grant after dropped req", gcount, 0);

        gf0 = {5{24'h5A5A5A}}; greq0 = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!gg0 && k < 5);
        check("u0 second game grant latency", k, 1);
        repeat (5000) @(negedge clk);
        rst0 = 1'b1; areq0 = 1'b1;
        @(negedge clk);
        check("u0 mid-SEND reset outputs", {gg0, ag0, busy0, dout0, fd0}, 5'b0);
        rst0 = 1'b0;
        @(negedge clk);
        check("u0 tie after reset grants game", {gg0, ag0}, 2'b10);
        greq0 = 1'b0; areq0 = 1'b0;
        repeat (15500) @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        check("u0 LATCH reset outputs", {gg0, ag0, busy0, dout0, fd0}, 5'b0);
        rst0 = 1'b0; areq0 = 1'b1; af0 = {5{24'hC3C3C3}};
        @(negedge clk);
        check("u0 grant right after reset", {gg0, ag0}, 2'b01);
        areq0 = 1'b0;
        repeat (10) @(negedge clk);
        done0 = 1'b1;
    end

    // ---------------- unit 1: round-robin ties ----------------
    initial begin
        int k;
        rst1 = 1'b1; greq1 = 1'b1; areq1 = 1'b1;
        gf1  = {5{24'h81F00F}}; af1 = {5{24'h3C3C3C}};
        repeat (2) @(negedge clk);
        rst1 = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!(gg1 || ag1) && k < 5);
        check("u1 first grant latency", k, 1);
        check("u1 first tie grant", {gg1, ag1}, 2'b10);
        k = 0;
        do begin @(negedge clk); k++; end while (!(gg1 || ag1) && k < 21100);
        check("u1 second grant spacing", k, 21001);
        check("u1 second tie grant", {gg1, ag1}, 2'b01);
        k = 0;
        do begin @(negedge clk); k++; end while (!(gg1 || ag1) && k < 21100);
        check("u1 third grant spacing", k, 21001);
        check("u1 third tie grant", {gg1, ag1}, 2'b10);
        greq1 = 1'b0; areq1 = 1'b0;
        repeat (3) @(negedge clk);
        done1 = 1'b1;
    end

    // ---------------- unit 2: override timing, one-LED frame ----------------
    initial begin
        int k, len;
        bit cur;
        int runs[$];
        int exp_hi[8] = '{7, 3, 7, 3, 3, 7, 3, 7};
        rst2 = 1'b1; greq2 = 1'b0; areq2 = 1'b0;
        gf2  = 24'hFFFFFF; af2 = 24'hA5A5A5;
        repeat (2) @(negedge clk);
        check("u2 reset outputs", {gg2, ag2, busy2, dout2, fd2}, 5'b0);
        rst2 = 1'b0; areq2 = 1'b1;
        @(negedge clk);
        areq2 = 1'b0;
        check("u2 anim grant", {gg2, ag2}, 2'b01);
        cur = dout2; len = 1; k = 0;
        while (!fd2 && k < 300) begin
            @(negedge clk); k++;
            if (fd2) runs.push_back(len);
            else if (dout2 == cur) len++;
            else begin runs.push_back(len); cur = dout2; len = 1; end
        end
        check("u2 grant-to-frame_done cycles", k, 260);
        check("u2 dout run count", runs.size(), 48);
        if (runs.size() >= 48) begin
            for (int i = 0; i < 24; i++)
                check($sformatf("u2 bit%0d high", i), runs[2 * i], exp_hi[i % 8]);
            check("u2 bit0 low", runs[1], 3);
            check("u2 bit1 low", runs[3], 7);
            check("u2 last low incl latch", runs[47], 23);
        end
        repeat (5) @(negedge clk);
        done2 = 1'b1;
    end

    initial begin
        wait (done0 && done1 && done2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, %0d of %0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
